ripple_tick_gen: RTL and testbench

- Upstream step-timing source for the 8-LED ripple shifter.
- Produces a single-cycle `tick` strobe; the shifter advances the LED pattern by one position per tick.
- Step rate is user-adjustable from three raw push buttons (faster, slower, pause/resume), each synchronized and debounced.
- Current speed level and pause state are exported for status LEDs.

---
 rtl/ripple_tick_gen.sv | 114 +++++++++++
 tb/tb_ripple_tick_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ripple_tick_gen.sv
// Step-timing strobe for the 8-LED ripple shifter: one-cycle tick every
// BASE_PERIOD >> speed_level cycles, adjusted by three debounced push buttons.
module ripple_tick_gen #(
    parameter int unsigned BASE_PERIOD     = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_faster,
    input  logic       btn_slower,
    input  logic       btn_pause,
    output logic       tick,
    output logic [2:0] speed_level,
    output logic       paused
);

    localparam logic [CNT_W-1:0] BASE     = CNT_W'(BASE_PERIOD);
    localparam logic [CNT_W-1:0] DB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // Button vector ordering: [0]=faster, [1]=slower, [2]=pause.
    logic [2:0]       w_raw;
    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [2:0]       r_db;
    logic [2:0]       r_db_d;
    logic [CNT_W-1:0] r_dbcnt [3];

    logic [2:0]       w_press;
    logic             w_level_up;
    logic             w_level_dn;
    logic             w_level_chg;
    logic [CNT_W-1:0] w_period;
    logic             w_term;

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [2:0]       r_level;
    logic             r_paused;

    assign w_raw = {btn_pause, btn_slower, btn_faster};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dbcnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_dbcnt[i] + ONE == DB_LIMIT) begin
                        r_db[i]    <= r_sync2[i];
                        r_dbcnt[i] <= '0;
                    end else begin
                        r_dbcnt[i] <= r_dbcnt[i] + ONE;
                    end
                end else begin
                    r_dbcnt[i] <= '0;
                end
            end
        end
    end

    // Presses only: a debounced release produces no pulse.
    assign w_press     = r_db & ~r_db_d;
    assign w_level_up  = w_press[0] & ~w_press[1] & (r_level != 3'd7);
    assign w_level_dn  = w_press[1] & ~w_press[0] & (r_level != 3'd0);
    assign w_level_chg = w_level_up | w_level_dn;
    assign w_period    = BASE >> r_level;
    assign w_term      = (r_cnt == w_period - ONE);

    // A pause pulse in either direction freezes the counter for that edge,
    // so pausing on terminal count keeps P-1 and resume ticks one edge later.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_tick   <= 1'b0;
            r_level  <= 3'd0;
            r_paused <= 1'b0;
        end else begin
            r_paused <= r_paused ^ w_press[2];
            if (w_level_up) begin
                r_level <= r_level + 3'd1;
            end else if (w_level_dn) begin
                r_level <= r_level - 3'd1;
            end
            if (w_level_chg) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else if (r_paused || w_press[2]) begin
                r_tick <= 1'b0;
            end else if (w_term) begin
                r_cnt  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + ONE;
                r_tick <= 1'b0;
            end
        end
    end

    assign tick        = r_tick;
    assign speed_level = r_level;
    assign paused      = r_paused;

endmodule

// File: tb/tb_ripple_tick_gen.sv
// Scoreboard bench for ripple_tick_gen: stimulus schedules expected tick edges,
// a negedge monitor matches every observed tick against that schedule.
module tb_ripple_tick_gen;

    localparam int BP = 256;
    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       bf;
    logic       bs;
    logic       bpz;
    logic       tick;
    logic [2:0] speed_level;
    logic       paused;

    ripple_tick_gen #(
        .BASE_PERIOD    (BP),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_faster (bf),
        .btn_slower (bs),
        .btn_pause  (bpz),
        .tick       (tick),
        .speed_level(speed_level),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;
    int exq[$];
    bit mon_en = 1'b0;

    // Expected tick schedule: next tick edge, current period, pause state.
    int t_next;
    int per;
    bit s_paused;
    int lp;
    int lvl;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_upto(input int x);
        if (!s_paused) begin
            while (t_next <= x) begin
                exq.push_back(t_next);
                t_next += per;
            end
        end
    endtask

    task automatic plan_change(input int l, input int newp);
        while (t_next < l) begin
            exq.push_back(t_next);
            t_next += per;
        end
        t_next = l + newp;
        per    = newp;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        wait_neg(n);
        chk("reset_tick", int'(tick), 0);
        chk("reset_level", int'(speed_level), 0);
        chk("reset_paused", int'(paused), 0);
        reset    = 1'b0;
        s_paused = 1'b0;
        per      = BP;
        t_next   = cyc + BP;
        lvl      = 0;
    endtask

    // Raw press starting at the current negedge; level changes on edge E+DB+3.
    task automatic press_lvl(input logic [2:0] m, input int newl);
        int e;
        e = cyc;
        if (newl != lvl) plan_change(e + DB + 3, BP >> newl);
        push_upto(e + 24);
        {bpz, bs, bf} = m;
        wait_neg(DB + 2);
        chk("level_before", int'(speed_level), lvl);
        wait_neg(1);
        chk("level_after", int'(speed_level), newl);
        lvl = newl;
        wait_neg(12 - DB - 3);
        {bpz, bs, bf} = 3'b000;
        wait_neg(12);
    endtask

    task automatic press_pause(input bit newp);
        int e;
        int l;
        e = cyc;
        l = e + DB + 3;
        if (newp) begin
            while (t_next < l) begin
                exq.push_back(t_next);
                t_next += per;
            end
            s_paused = 1'b1;
            lp       = l;
        end else begin
            t_next   = t_next + (l - lp + 1);
            s_paused = 1'b0;
        end
        push_upto(e + 24);
        bpz = 1'b1;
        wait_neg(DB + 2);
        chk("paused_before", int'(paused), int'(!newp));
        wait_neg(1);
        chk("paused_after", int'(paused), int'(newp));
        wait_neg(12 - DB - 3);
        bpz = 1'b0;
        wait_neg(12);
    endtask

    // Monitor: every tick must land on the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tick) begin
                int e;
                e = (exq.size() > 0) ? exq[0] : -1;
                chk("tick_edge", cyc, e);
                if (e == cyc) void'(exq.pop_front());
            end else if (exq.size() > 0 && exq[0] <= cyc) begin
                chk("tick_missing", int'(tick), 1);
                void'(exq.pop_front());
            end
        end
    end

    initial begin
        reset    = 1'b1;
        bf       = 1'b0;
        bs       = 1'b0;
        bpz      = 1'b0;
        s_paused = 1'b0;
        @(negedge clk);
        do_reset(3);
        mon_en = 1'b1;

        // Idle run at level 0.
        push_upto(cyc + 1100);
        for (int i = 0; i < 11; i++) begin
            wait_neg(100);
            chk("idle_level", int'(speed_level), 0);
            chk("idle_paused", int'(paused), 0);
        end

        // Short glitch is ignored, then a real press.
        push_upto(cyc + 15);
        bf = 1'b1;
        wait_neg(DB - 1);
        bf = 1'b0;
        wait_neg(12);
        chk("glitch_level", int'(speed_level), 0);
        press_lvl(3'b001, 1);
        push_upto(cyc + 300);
        wait_neg(300);

        // Ten faster presses saturate at level 7.
        for (int i = 0; i < 10; i++) begin
            press_lvl(3'b001, (lvl < 7) ? lvl + 1 : 7);
        end
        push_upto(cyc + 20);
        wait_neg(20);
        chk("sat_level", int'(speed_level), 7);

        // Down to level 2, then pause with the counter at 40.
        for (int i = 0; i < 5; i++) begin
            press_lvl(3'b010, lvl - 1);
        end
        while (t_next - 30 <= cyc) push_upto(t_next);
        wait_neg(t_next - 30 - cyc);
        press_pause(1'b1);
        wait_neg(500);
        chk("held_paused", int'(paused), 1);
        press_pause(1'b0);
        push_upto(cyc + 200);
        wait_neg(200);

        // Simultaneous faster+slower at level 3 changes nothing.
        press_lvl(3'b001, 3);
        push_upto(cyc + 30);
        bf = 1'b1;
        bs = 1'b1;
        wait_neg(DB + 3);
        chk("both_level", int'(speed_level), 3);
        wait_neg(12 - DB - 3);
        bf = 1'b0;
        bs = 1'b0;
        wait_neg(12);
        push_upto(cyc + 100);
        wait_neg(100);
        chk("both_level_late", int'(speed_level), 3);

        // Reset while at level 5 and paused.
        press_lvl(3'b001, 4);
        press_lvl(3'b001, 5);
        press_pause(1'b1);
        wait_neg(20);
        do_reset(1);
        push_upto(cyc + 600);
        wait_neg(600);

        chk("queue_drained", exq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
